// File: rtl/fifo_flops_fwft.sv
// fifo_flops_fwft: flop-based first-word-fall-through FIFO.
// Circular buffer of `depth` registers addressed by explicitly wrapping
// read/write pointers, so any depth >= 2 works. Provides an occupancy count,
// programmable almost-full/almost-empty flags and registered one-cycle
// overflow/underflow pulses for rejected requests.
module fifo_flops_fwft #(
    parameter int depth  = 16,
    parameter int bits   = 32,
    parameter int af_lvl = depth - 2,
    parameter int ae_lvl = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [bits-1:0]            Din,
    input  logic                       push,
    input  logic                       pop,
    output logic [bits-1:0]            Dout,
    output logic                       full,
    output logic                       pndng,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST_PTR  = ptr_t'(depth - 1);
    localparam cnt_t DEPTH_CNT = cnt_t'(depth);
    localparam cnt_t AF_CNT    = cnt_t'(af_lvl);
    localparam cnt_t AE_CNT    = cnt_t'(ae_lvl);

    logic [bits-1:0] mem_q [depth];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q,  count_d;
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    logic pop_acc;
    logic push_acc;

    // Accept decisions from the current count, then next pointers, count and error pulses.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
        pop_acc     = pop && (count_q != '0);
        push_acc    = push && ((count_q != DEPTH_CNT) || pop_acc);

        overflow_d  = push && !push_acc;
        underflow_d = pop && !pop_acc;

        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ptr_t'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: synchronous reset wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; Dout is masked to zero while empty, so stale words never show.
        if (!rst && push_acc) begin
            mem_q[wr_ptr_q] <= Din;
        end
    end

    // Outputs are decoded from registered state only, so they are stable within a cycle.
    assign Dout         = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign full         = (count_q == DEPTH_CNT);
    assign pndng        = (count_q != '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flops_fwft.sv
// tb_fifo_flops_fwft: drives a depth-16 and a depth-5 FIFO with the same
// stimulus and compares every output each cycle against queue-based models.
module tb_fifo_flops_fwft;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        pop;
    logic [31:0] din;

    // depth 16 instance (default levels: af 14, ae 2)
    logic [31:0] dout_a;
    logic [4:0]  count_a;
    logic        full_a, pndng_a, af_a, ae_a, ov_a, un_a;

    // depth 5 instance (af 5, ae 1)
    logic [31:0] dout_b;
    logic [2:0]  count_b;
    logic        full_b, pndng_b, af_b, ae_b, ov_b, un_b;

    always #5 clk = ~clk;

    fifo_flops_fwft #(.depth(16), .bits(32), .af_lvl(14), .ae_lvl(2)) dut_a (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop),
        .Dout(dout_a), .full(full_a), .pndng(pndng_a), .count(count_a),
        .almost_full(af_a), .almost_empty(ae_a),
        .overflow(ov_a), .underflow(un_a)
    );

    fifo_flops_fwft #(.depth(5), .bits(32), .af_lvl(5), .ae_lvl(1)) dut_b (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop),
        .Dout(dout_b), .full(full_b), .pndng(pndng_b), .count(count_b),
        .almost_full(af_b), .almost_empty(ae_b),
        .overflow(ov_b), .underflow(un_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: contents as a queue plus expected error pulses.
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    bit          eov_a, eun_a, eov_b, eun_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge of the FIFO rules to a model queue.
    task automatic model_step(inout logic [31:0] q[$], input int d, output bit ov, output bit un);
        bit pop_ok, push_ok;
        if (rst) begin
            q.delete();
            ov = 1'b0;
            un = 1'b0;
        end else begin
            pop_ok  = pop && (q.size() > 0);
            push_ok = push && ((q.size() < d) || pop_ok);
            ov      = push && !push_ok;
            un      = pop && !pop_ok;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(din);
        end
    endtask

    task automatic compare(input string p, input int d, input int af, input int ae,
                           input logic [31:0] q[$], input bit ov, input bit un,
                           input logic [31:0] g_dout, input logic [7:0] g_cnt,
                           input logic g_full, input logic g_pndng, input logic g_af,
                           input logic g_ae, input logic g_ov, input logic g_un);
        int n;
        logic [31:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : 32'h0;
        check({p, ".count"},        g_cnt,   n);
        check({p, ".dout"},         g_dout,  head);
        check({p, ".full"},         g_full,  n == d);
        check({p, ".pndng"},        g_pndng, n != 0);
        check({p, ".almost_full"},  g_af,    n >= af);
        check({p, ".almost_empty"}, g_ae,    n <= ae);
        check({p, ".overflow"},     g_ov,    ov);
        check({p, ".underflow"},    g_un,    un);
    endtask

    // Drive one cycle of inputs, advance the models at the edge, check 1 time unit later.
    task automatic step(input bit r, input bit pu, input bit po, input logic [31:0] di);
        rst  = r;
        push = pu;
        pop  = po;
        din  = di;
        @(posedge clk);
        model_step(q_a, 16, eov_a, eun_a);
        model_step(q_b, 5,  eov_b, eun_b);
        #1;
        compare("d16", 16, 14, 2, q_a, eov_a, eun_a, dout_a, 8'(count_a),
                full_a, pndng_a, af_a, ae_a, ov_a, un_a);
        compare("d5",  5,  5,  1, q_b, eov_b, eun_b, dout_b, 8'(count_b),
                full_b, pndng_b, af_b, ae_b, ov_b, un_b);
    endtask

    // Watchdog: the stimulus is fixed-length, so this only fires on a broken run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;

        // Reset held with a push pending must leave both FIFOs empty.
        step(1, 1, 0, 32'hA5);
        step(1, 1, 0, 32'hA5);
        step(0, 0, 0, 32'h0);

        // Fill 0..15, then a rejected push on full, then idle.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 32'(i));
        step(0, 1, 0, 32'hDEAD);
        step(0, 0, 0, 32'h0);

        // Drain, then a rejected pop on empty, then idle.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 32'h0);
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 32'h0);

        // Full with simultaneous push+pop: 0x77 becomes the tail.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 32'h100 + 32'(i));
        step(0, 1, 1, 32'h77);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 32'h0);

        // Empty with simultaneous push+pop: push lands, pop underflows.
        step(0, 1, 1, 32'h33);
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 32'h0);

        // Interleaved traffic to walk the depth-5 pointers through their wrap.
        for (int i = 0; i < 12; i++) step(0, 1, (i >= 3) && (i % 2 == 1), 32'h200 + 32'(i));
        for (int i = 0; i < 6; i++)  step(0, 0, 1, 32'h0);

        // Reset mid-stream with a push pending, then a single push.
        for (int i = 0; i < 7; i++) step(0, 1, 0, 32'h300 + 32'(i));
        step(1, 1, 0, 32'hBB);
        step(0, 1, 0, 32'h1);
        step(0, 0, 0, 32'h0);

        // Random traffic with push bias moving from fill-heavy to drain-heavy.
        for (int phase = 0; phase < 3; phase++) begin
            int push_pct;
            push_pct = 75 - phase * 25;
            for (int i = 0; i < 700; i++) begin
                bit r, pu, po;
                r  = ($urandom_range(0, 299) == 0);
                pu = ($urandom_range(0, 99) < push_pct);
                po = ($urandom_range(0, 99) < 50);
                step(r, pu, po, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
